// File: rtl/ac_motor_pkg.sv
// Shared constants and FSM state encoding for the AC motor frequency ramp controller.
package ac_motor_pkg;

   localparam int unsigned AC_MOTOR_FREQ_WIDTH   = 12;
   localparam int unsigned AC_MOTOR_SECTOR_WIDTH = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAMP = 2'd1,
      ST_RUN  = 2'd2,
      ST_STOP = 2'd3
   } state_e;

endpackage

// File: rtl/ac_motor_ramp_prescaler.sv
// Free-running 0..PRESCALE-1 counter producing a one-cycle ramp tick on its last count.
module ac_motor_ramp_prescaler #(
   parameter int unsigned PRESCALE = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clear || tick) cnt_d = '0;
   end

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/ac_motor_freq_ramp_ctrl.sv
// Soft-start/soft-stop frequency ramp FSM for the sine-sector generator.
// Define AC_MOTOR_RAMP_SECTOR_SYNC_EN to defer ramp steps to sector boundaries.
module ac_motor_freq_ramp_ctrl
   import ac_motor_pkg::*;
#(
   parameter int unsigned FREQ_WIDTH = AC_MOTOR_FREQ_WIDTH,
   parameter int unsigned PRESCALE   = 1000,
   parameter int unsigned STEP       = 1,
   parameter int unsigned MIN_FREQ   = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             enable,
   input  logic [FREQ_WIDTH-1:0]            target_freq,
   input  logic [AC_MOTOR_SECTOR_WIDTH-1:0] sector,
   output logic [FREQ_WIDTH-1:0]            frequency,
   output logic                             running,
   output logic                             at_speed,
   output logic [1:0]                       state
);

   localparam int unsigned XW = FREQ_WIDTH + 1;
   localparam logic [XW-1:0]         STEP_X = XW'(STEP);
   localparam logic [XW-1:0]         MIN_X  = XW'(MIN_FREQ);
   localparam logic [FREQ_WIDTH-1:0] STEP_W = FREQ_WIDTH'(STEP);
   localparam logic [FREQ_WIDTH-1:0] MIN_W  = FREQ_WIDTH'(MIN_FREQ);

   state_e                  state_q, state_d;
   logic [FREQ_WIDTH-1:0]   freq_q, freq_d;
   logic                    running_q, at_speed_q;
   logic [XW-1:0]           freq_x, tgt_x, sum_x;
   logic [FREQ_WIDTH-1:0]   ramp_val, stop_val, step_val, upd_val;
   logic                    upd_vld, stop_req, tick, presc_clear;

   ac_motor_ramp_prescaler #(.PRESCALE(PRESCALE)) u_presc (
      .clk   (clk),
      .reset (reset),
      .clear (presc_clear),
      .tick  (tick)
   );

   assign freq_x   = {1'b0, freq_q};
   assign tgt_x    = {1'b0, target_freq};
   assign sum_x    = freq_x + STEP_X;
   assign stop_req = !enable || (tgt_x < MIN_X);

   // Saturating steps: ramp clamps at the target, stop clamps at MIN_FREQ.
   always_comb begin
      ramp_val = target_freq;
      if (freq_x < tgt_x) begin
         if (sum_x < tgt_x) ramp_val = sum_x[FREQ_WIDTH-1:0];
      end else if (freq_x > tgt_x + STEP_X) begin
         ramp_val = freq_q - STEP_W;
      end
      stop_val = MIN_W;
      if (freq_x > MIN_X + STEP_X) stop_val = freq_q - STEP_W;
      step_val = (state_q == ST_STOP) ? stop_val : ramp_val;
   end

`ifdef AC_MOTOR_RAMP_SECTOR_SYNC_EN
   logic [AC_MOTOR_SECTOR_WIDTH-1:0] sector_q;
   logic [FREQ_WIDTH-1:0]            pend_q, pend_d;
   logic                             pend_vld_q, pend_vld_d;

   // A step computed this cycle beats the stored one if the sector edge coincides.
   assign upd_vld = (sector != sector_q) && (tick || pend_vld_q);
   assign upd_val = tick ? step_val : pend_q;

   always_comb begin
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      if (state_d != state_q || upd_vld) begin
         pend_vld_d = 1'b0;
      end else if (tick && (state_q == ST_RAMP || state_q == ST_STOP)) begin
         pend_d     = step_val;
         pend_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sector_q   <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
      end else begin
         sector_q   <= sector;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
      end
   end
`else
   logic unused_sector;
   assign unused_sector = ^sector;
   assign upd_vld       = tick;
   assign upd_val       = step_val;
`endif

   // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
   always_comb begin
      state_d = state_q;
      freq_d  = freq_q;
      unique case (state_q)
         ST_IDLE: begin
            if (!stop_req) begin
               state_d = ST_RAMP;
               freq_d  = MIN_W;
            end
         end
         ST_RAMP: begin
            if (stop_req) begin
               state_d = ST_STOP;
            end else if (upd_vld) begin
               freq_d = upd_val;
               if (upd_val == target_freq) state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (stop_req)                    state_d = ST_STOP;
            else if (target_freq != freq_q)  state_d = ST_RAMP;
         end
         ST_STOP: begin
            if (!stop_req) begin
               state_d = ST_RAMP;
            end else if (tick && freq_x == MIN_X) begin
               freq_d  = '0;
               state_d = ST_IDLE;
            end else if (upd_vld) begin
               freq_d = upd_val;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign presc_clear = (state_d != state_q) && (state_d == ST_RAMP || state_d == ST_STOP);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         freq_q     <= '0;
         running_q  <= 1'b0;
         at_speed_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         freq_q     <= freq_d;
         running_q  <= (state_d != ST_IDLE);
         at_speed_q <= (state_d == ST_RUN);
      end
   end

   assign frequency = freq_q;
   assign running   = running_q;
   assign at_speed  = at_speed_q;
   assign state     = state_q;

endmodule

// File: tb/tb_ac_motor_freq_ramp_ctrl.sv
// Directed self-checking bench for ac_motor_freq_ramp_ctrl (PRESCALE=4, STEP=8, MIN_FREQ=16).
// With AC_MOTOR_RAMP_SECTOR_SYNC_EN defined only the sector-sync sequence runs.
module tb_ac_motor_freq_ramp_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [11:0] target_freq;
   logic [2:0]  sector;
   logic [11:0] frequency;
   logic        running;
   logic        at_speed;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;

   ac_motor_freq_ramp_ctrl #(
      .FREQ_WIDTH (12),
      .PRESCALE   (4),
      .STEP       (8),
      .MIN_FREQ   (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .target_freq (target_freq),
      .sector      (sector),
      .frequency   (frequency),
      .running     (running),
      .at_speed    (at_speed),
      .state       (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset       = 1'b1;
      enable      = 1'b1;
      target_freq = 12'd64;
      sector      = 3'd0;
      step(3);
      check("rst_freq",     32'(frequency), 32'd0);
      check("rst_state",    32'(state),     32'd0);
      check("rst_running",  32'(running),   32'd0);
      check("rst_at_speed", 32'(at_speed),  32'd0);

`ifdef AC_MOTOR_RAMP_SECTOR_SYNC_EN
      sector = 3'd3;
      reset  = 1'b0;
      step(1);
      check("sync_start_freq",  32'(frequency), 32'd16);
      check("sync_start_state", 32'(state),     32'd1);
      step(12);
      check("sync_frozen_freq", 32'(frequency), 32'd16);
      check("sync_frozen_st",   32'(state),     32'd1);
      sector = 3'd4;
      step(1);
      check("sync_applied",     32'(frequency), 32'd24);
      step(1);
      check("sync_hold_after",  32'(frequency), 32'd24);
`else
      reset = 1'b0;
      step(1);
      check("start_freq",    32'(frequency), 32'd16);
      check("start_state",   32'(state),     32'd1);
      check("start_running", 32'(running),   32'd1);
      step(3);
      check("pre_tick_hold", 32'(frequency), 32'd16);
      step(1);
      check("first_tick",    32'(frequency), 32'd24);
      step(16);
      check("ramp_56",       32'(frequency), 32'd56);
      check("ramp_state",    32'(state),     32'd1);
      step(4);
      check("reach_64",      32'(frequency), 32'd64);
      check("run_state",     32'(state),     32'd2);
      check("run_at_speed",  32'(at_speed),  32'd1);

      // Lower target from RUN.
      target_freq = 12'd40;
      step(1);
      check("retarget_state", 32'(state),    32'd1);
      check("retarget_atspd", 32'(at_speed), 32'd0);
      check("retarget_hold",  32'(frequency), 32'd64);
      step(4);
      check("down_56",        32'(frequency), 32'd56);
      step(8);
      check("down_40",        32'(frequency), 32'd40);
      check("down_run",       32'(state),     32'd2);

      // Raise to 70: last step clamps 64 -> 70.
      target_freq = 12'd70;
      step(1);
      check("up70_state", 32'(state), 32'd1);
      step(12);
      check("up70_64",    32'(frequency), 32'd64);
      step(4);
      check("up70_clamp", 32'(frequency), 32'd70);
      check("up70_run",   32'(state),     32'd2);

      // Stop and target change together: stop wins.
      enable      = 1'b0;
      target_freq = 12'd100;
      step(1);
      check("stop_wins",     32'(state),     32'd3);
      check("stop_hold",     32'(frequency), 32'd70);
      step(4);
      check("stop_62",       32'(frequency), 32'd62);
      step(20);
      check("stop_22",       32'(frequency), 32'd22);
      step(4);
      check("stop_clamp16",  32'(frequency), 32'd16);
      check("stop_still",    32'(state),     32'd3);
      step(4);
      check("stop_zero",     32'(frequency), 32'd0);
      check("stop_idle",     32'(state),     32'd0);
      check("stop_not_run",  32'(running),   32'd0);

      // Restart to 40, stop, then resume at 24.
      enable      = 1'b1;
      target_freq = 12'd40;
      step(1);
      check("restart_16", 32'(frequency), 32'd16);
      step(12);
      check("restart_40", 32'(frequency), 32'd40);
      check("restart_run", 32'(state),    32'd2);
      enable = 1'b0;
      step(1);
      check("stop2_state", 32'(state), 32'd3);
      step(8);
      check("stop2_24",    32'(frequency), 32'd24);
      enable = 1'b1;
      step(1);
      check("resume_state", 32'(state),     32'd1);
      check("resume_hold",  32'(frequency), 32'd24);
      step(4);
      check("resume_32",    32'(frequency), 32'd32);
      step(4);
      check("resume_40",    32'(frequency), 32'd40);
      check("resume_run",   32'(state),     32'd2);

      // Target below MIN_FREQ from RUN stops down to 0.
      target_freq = 12'd8;
      step(1);
      check("lowtgt_stop", 32'(state), 32'd3);
      step(12);
      check("lowtgt_16",   32'(frequency), 32'd16);
      step(4);
      check("lowtgt_zero", 32'(frequency), 32'd0);
      check("lowtgt_idle", 32'(state),     32'd0);

      // Enabled with target below MIN_FREQ stays parked.
      step(10);
      check("low_idle_state", 32'(state),     32'd0);
      check("low_idle_freq",  32'(frequency), 32'd0);

      // Reset mid-ramp drops straight to 0.
      target_freq = 12'd64;
      step(9);
      check("midramp_32", 32'(frequency), 32'd32);
      reset = 1'b1;
      step(1);
      check("midrst_freq",  32'(frequency), 32'd0);
      check("midrst_state", 32'(state),     32'd0);
      check("midrst_run",   32'(running),   32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
